snax_exercise_csrman: RTL
=========================

SNAX_EXERCISE_CSRMAN -- requirements
Module: snax_exercise_csrman

Interface
REQ-001: Parameter RegDataWidth, default 32: width of every CSR data path.
REQ-002: Parameter RegAddrWidth, default 32: width of the core request address (word index, not byte address).
REQ-003: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_ni  input  1  reset; asynchronous, active-low.
REQ-005: csr_req_addr_i  input  RegAddrWidth  CSR index of the core request.
REQ-006: csr_req_data_i  input  RegDataWidth  write data.
REQ-007: csr_req_write_i  input  1  1 = write, 0 = read.
REQ-008: csr_req_valid_i / csr_req_ready_o  input / output  1 each  core request handshake.
REQ-009: csr_rsp_data_o  output  RegDataWidth  read response data.
REQ-010: csr_rsp_valid_o / csr_rsp_ready_i  output / input  1 each  read response handshake.
REQ-011: csr_rw_reg_upper_o, csr_rw_reg_lower_o, csr_rw_reg_len_o, csr_rw_reg_start_o  output  RegDataWidth each  register set driven to the accelerator.
REQ-012: csr_rw_reg_valid_o / csr_rw_reg_ready_i  output / input  1 each  commit handshake towards the accelerator.
REQ-013: csr_ro_reg_busy_i, csr_ro_reg_perf_count_i  input  RegDataWidth each  read-only status from the accelerator.

Function
REQ-014: Address map SHALL be: 0 upper, 1 lower, 2 len, 3 start (RW shadow); 4 busy, 5 perf_count (RO, sampled live).
REQ-015: A request SHALL be accepted on the cycle in which csr_req_valid_i && csr_req_ready_o is high.
REQ-016: An accepted write to address 0..2 SHALL update the matching shadow register on that edge; it produces no response.
REQ-017: An accepted write to address 3 SHALL update the start shadow and move the FSM from IDLE to COMMIT on that edge.
REQ-018: FSM states: IDLE (csr_rw_reg_valid_o = 0) and COMMIT (csr_rw_reg_valid_o = 1).
- COMMIT -> IDLE on the cycle where csr_rw_reg_ready_i = 1.
- No other transitions.
REQ-019: Latency from start-write acceptance to csr_rw_reg_valid_o high SHALL be exactly 1 cycle.
REQ-020: While in COMMIT, all four csr_rw_reg_*_o outputs SHALL hold stable; they always equal the shadow registers.
REQ-021: While in COMMIT, csr_req_ready_o SHALL be 0 for write requests.
REQ-022: Read requests SHALL be accepted in either state.
REQ-023: csr_req_ready_o SHALL equal (!csr_req_write_i || state == IDLE) && (csr_req_write_i || !csr_rsp_valid_o || csr_rsp_ready_i).
REQ-024: An accepted read SHALL load csr_rsp_data_o and set csr_rsp_valid_o on the next edge (1-cycle latency).
- Read data for 0..3 is the shadow value; for 4..5 it is the RO input value sampled at acceptance.
REQ-025: csr_rsp_valid_o SHALL stay high, with data stable, until csr_rsp_ready_i = 1.
- Back-to-back reads SHALL be sustained at one per cycle when csr_rsp_ready_i is held high.
REQ-026: Writes to addresses 4, 5 or >5 SHALL be accepted and ignored.
REQ-027: Reads of addresses >5 SHALL return 0.
REQ-028: A start write accepted while csr_ro_reg_busy_i != 0 SHALL still enter COMMIT; stalling is the accelerator's job via csr_rw_reg_ready_i.
REQ-029: If csr_rw_reg_ready_i is high in IDLE, it SHALL have no effect.

Reset
REQ-030: On rst_ni low, the block SHALL asynchronously clear all shadow registers, the FSM to IDLE, csr_rw_reg_valid_o, csr_rsp_valid_o and csr_rsp_data_o to 0.
REQ-031: Reset asserted mid-COMMIT SHALL drop csr_rw_reg_valid_o immediately; no commit is replayed after reset.
REQ-032: During reset, csr_req_ready_o SHALL be 1 for reads and writes (IDLE, response slot empty).

Structure
REQ-033: Package snax_exercise_pkg SHALL hold the CSR index constants (0..5), NumRwCsr = 4, NumRoCsr = 2 and the FSM state enum.
REQ-034: The block SHALL be a single module with no sub-modules; the response slot is an inline single-entry register.

Verification
REQ-035: Write upper=0x10, lower=0x20, len=8, then start=1 with csr_rw_reg_ready_i held 0 for 3 cycles -> valid_o high 1 cycle after the start write, outputs 0x10/0x20/8/1 stable all 3 cycles, valid_o low the cycle after ready_i=1.
REQ-036: During COMMIT, issue write upper=0xFF -> csr_req_ready_o=0 until commit completes, then accepted and upper_o=0xFF.
REQ-037: busy_i=1, perf_count_i=0x1234, back-to-back reads of 4, 5, 2 with csr_rsp_ready_i=1 -> responses 1, 0x1234, 8 on 3 consecutive cycles.
REQ-038: Read address 4 with csr_rsp_ready_i=0 for 2 cycles, then issue a second read -> data held, second read stalled until the first response handshake.
REQ-039: Read address 9 -> 0; write address 5 = 0x77 -> accepted, a later read of 5 returns perf_count_i.
REQ-040: Pull rst_ni low during COMMIT -> valid_o=0 and all outputs 0 the same cycle; after release, state is IDLE with no commit.

Source files
------------

// File: rtl/snax_exercise_pkg.sv
// Shared constants for the SNAX exercise CSR manager: CSR index map,
// register counts and the commit FSM state type.
package snax_exercise_pkg;

  // Read/write shadow registers, forwarded to the accelerator on commit
  localparam int unsigned CsrIdxUpper = 0;
  localparam int unsigned CsrIdxLower = 1;
  localparam int unsigned CsrIdxLen   = 2;
  localparam int unsigned CsrIdxStart = 3;

  // Read-only status registers, sampled live from the accelerator
  localparam int unsigned CsrIdxBusy      = 4;
  localparam int unsigned CsrIdxPerfCount = 5;

  localparam int unsigned NumRwCsr = 4;
  localparam int unsigned NumRoCsr = 2;

  // IDLE: no commit outstanding. COMMIT: register set offered to the accelerator.
  typedef enum logic [0:0] {
    StateIdle   = 1'b0,
    StateCommit = 1'b1
  } csrman_state_e;

endpackage : snax_exercise_pkg

// File: rtl/snax_exercise_csrman.sv
// CSR manager for the SNAX exercise accelerator. Holds four RW shadow
// registers, offers them to the accelerator through a valid/ready commit
// handshake triggered by a write to the start CSR, and answers core reads
// through a single-entry response slot.
module snax_exercise_csrman
  import snax_exercise_pkg::*;
#(
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic [RegAddrWidth-1:0] csr_req_addr_i,
  input  logic [RegDataWidth-1:0] csr_req_data_i,
  input  logic                    csr_req_write_i,
  input  logic                    csr_req_valid_i,
  output logic                    csr_req_ready_o,

  output logic [RegDataWidth-1:0] csr_rsp_data_o,
  output logic                    csr_rsp_valid_o,
  input  logic                    csr_rsp_ready_i,

  output logic [RegDataWidth-1:0] csr_rw_reg_upper_o,
  output logic [RegDataWidth-1:0] csr_rw_reg_lower_o,
  output logic [RegDataWidth-1:0] csr_rw_reg_len_o,
  output logic [RegDataWidth-1:0] csr_rw_reg_start_o,
  output logic                    csr_rw_reg_valid_o,
  input  logic                    csr_rw_reg_ready_i,

  input  logic [RegDataWidth-1:0] csr_ro_reg_busy_i,
  input  logic [RegDataWidth-1:0] csr_ro_reg_perf_count_i
);

  csrman_state_e r_state;

  logic [RegDataWidth-1:0] r_upper;
  logic [RegDataWidth-1:0] r_lower;
  logic [RegDataWidth-1:0] r_len;
  logic [RegDataWidth-1:0] r_start;

  logic [RegDataWidth-1:0] r_rsp_data;
  logic                    r_rsp_valid;

  logic                    w_req_ready;
  logic                    w_accept;
  logic                    w_accept_write;
  logic                    w_accept_read;
  logic                    w_addr_upper;
  logic                    w_addr_lower;
  logic                    w_addr_len;
  logic                    w_addr_start;
  logic                    w_addr_busy;
  logic                    w_addr_perf;
  logic [RegDataWidth-1:0] w_read_data;

  // Address decode; anything outside 0..5 decodes to nothing
  assign w_addr_upper = (csr_req_addr_i == RegAddrWidth'(CsrIdxUpper));
  assign w_addr_lower = (csr_req_addr_i == RegAddrWidth'(CsrIdxLower));
  assign w_addr_len   = (csr_req_addr_i == RegAddrWidth'(CsrIdxLen));
  assign w_addr_start = (csr_req_addr_i == RegAddrWidth'(CsrIdxStart));
  assign w_addr_busy  = (csr_req_addr_i == RegAddrWidth'(CsrIdxBusy));
  assign w_addr_perf  = (csr_req_addr_i == RegAddrWidth'(CsrIdxPerfCount));

  // Writes wait while a commit is outstanding so the offered register set
  // cannot change under the accelerator; reads wait only for a free slot.
  assign w_req_ready = (!csr_req_write_i || (r_state == StateIdle)) &&
                       (csr_req_write_i || !r_rsp_valid || csr_rsp_ready_i);

  assign w_accept       = csr_req_valid_i && w_req_ready;
  assign w_accept_write = w_accept && csr_req_write_i;
  assign w_accept_read  = w_accept && !csr_req_write_i;

  // Read data mux: shadows, live RO status, zero for unmapped indices
  always_comb begin
    w_read_data = '0;
    if (w_addr_upper)     w_read_data = r_upper;
    else if (w_addr_lower) w_read_data = r_lower;
    else if (w_addr_len)   w_read_data = r_len;
    else if (w_addr_start) w_read_data = r_start;
    else if (w_addr_busy)  w_read_data = csr_ro_reg_busy_i;
    else if (w_addr_perf)  w_read_data = csr_ro_reg_perf_count_i;
  end

  // Shadow register updates on accepted writes; RO and unmapped writes are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_upper <= '0;
      r_lower <= '0;
      r_len   <= '0;
      r_start <= '0;
    end else if (w_accept_write) begin
      if (w_addr_upper) r_upper <= csr_req_data_i;
      if (w_addr_lower) r_lower <= csr_req_data_i;
      if (w_addr_len)   r_len   <= csr_req_data_i;
      if (w_addr_start) r_start <= csr_req_data_i;
    end
  end

  // Commit FSM: a start write launches a commit, accelerator ready retires it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StateIdle;
    end else begin
      case (r_state)
        StateIdle: begin
          if (w_accept_write && w_addr_start) r_state <= StateCommit;
        end
        StateCommit: begin
          if (csr_rw_reg_ready_i) r_state <= StateIdle;
        end
        default: r_state <= StateIdle;
      endcase
    end
  end

  // Single-entry response slot: load on read accept, drain on response handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_accept_read) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_read_data;
    end else if (csr_rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign csr_req_ready_o    = w_req_ready;
  assign csr_rsp_data_o     = r_rsp_data;
  assign csr_rsp_valid_o    = r_rsp_valid;
  assign csr_rw_reg_upper_o = r_upper;
  assign csr_rw_reg_lower_o = r_lower;
  assign csr_rw_reg_len_o   = r_len;
  assign csr_rw_reg_start_o = r_start;
  assign csr_rw_reg_valid_o = (r_state == StateCommit);

endmodule : snax_exercise_csrman
